// File: rtl/mmio_clint_multi.sv
// mmio_clint_multi: multi-hart CLINT MMIO slave.
// Owns the 64-bit mtime counter (1 MHz tick from an FMAX_MHz prescaler),
// one mtimecmp per hart and, when MMIO_CLINT_MSIP_EN is defined, one msip bit per hart.
// Without MMIO_CLINT_MSIP_EN the msip window reads 0, ignores writes and msip is tied low.
// Register reads are sampled from pre-write state and returned one cycle after accept.
module mmio_clint_multi #(
    parameter int          FMAX_MHz  = 27,
    parameter int          NHART     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             req_ready,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic             req_wen,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [63:0]      mtime,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip
);

    localparam int            PW   = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
    localparam logic [PW-1:0] PMAX = PW'(FMAX_MHz - 1);

    logic [PW-1:0]    r_presc;
    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp [NHART];
    logic [NHART-1:0] r_mtip;
    logic             r_respValid;
    logic [31:0]      r_respRdata;

    logic [31:0] w_offFull;
    logic [15:0] w_off;
    logic [10:0] w_cmpIdx;
    logic        w_accept;
    logic        w_wr;
    logic        w_isCmp;
    logic        w_isTimeLo;
    logic        w_isTimeHi;
    logic        w_tick;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign req_ready  = ~reset;
    assign w_accept   = req_valid & req_ready;
    assign w_wr       = w_accept & req_wen;
    assign w_offFull  = req_addr - BASE_ADDR;
    assign w_off      = w_offFull[15:0];
    assign w_cmpIdx   = w_off[13:3];
    assign w_isCmp    = (w_off[15:14] == 2'b01);
    assign w_isTimeLo = (w_off[15:2] == 14'h2FFE);
    assign w_isTimeHi = (w_off[15:2] == 14'h2FFF);
    assign w_tick     = (r_presc == PMAX);
    assign w_unused   = ^{w_offFull[31:16], w_off[1:0]};

    assign mtime      = r_mtime;
    assign mtip       = r_mtip;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;

`ifdef MMIO_CLINT_MSIP_EN
    logic [NHART-1:0] r_msip;
    logic [11:0]      w_msipIdx;
    logic             w_isMsip;

    assign w_msipIdx = w_off[13:2];
    assign w_isMsip  = (w_off[15:14] == 2'b00);
    assign msip      = r_msip;

    // Software interrupt bits: only bit 0 of the write data is stored per hart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msip <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                if (w_wr && w_isMsip && (w_msipIdx == 12'(h))) begin
                    r_msip[h] <= req_wdata[0];
                end
            end
        end
    end
`else
    assign msip = '0;
`endif

    // Read mux over the current register values, so a same-edge write is not visible
    always_comb begin
        w_rdata = '0;
        if (w_isTimeLo) begin
            w_rdata = r_mtime[31:0];
        end else if (w_isTimeHi) begin
            w_rdata = r_mtime[63:32];
        end else if (w_isCmp) begin
            for (int h = 0; h < NHART; h++) begin
                if (w_cmpIdx == 11'(h)) begin
                    w_rdata = w_off[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
                end
            end
        end
`ifdef MMIO_CLINT_MSIP_EN
        else if (w_isMsip) begin
            for (int h = 0; h < NHART; h++) begin
                if (w_msipIdx == 12'(h)) begin
                    w_rdata = {31'b0, r_msip[h]};
                end
            end
        end
`endif
    end

    // One-cycle response pulse for every accepted request; writes return 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_respValid <= 1'b0;
            r_respRdata <= '0;
        end else begin
            r_respValid <= w_accept;
            r_respRdata <= (w_accept && !req_wen) ? w_rdata : 32'h0;
        end
    end

    // Prescaler and mtime: a bus write to either half wins over the tick on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_wr && w_isTimeLo) begin
                r_mtime[31:0] <= req_wdata;
            end else if (w_wr && w_isTimeHi) begin
                r_mtime[63:32] <= req_wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    // Per-hart compare registers, written one 32-bit half at a time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < NHART; h++) begin
                r_mtimecmp[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NHART; h++) begin
                if (w_wr && w_isCmp && (w_cmpIdx == 11'(h))) begin
                    if (w_off[2]) begin
                        r_mtimecmp[h][63:32] <= req_wdata;
                    end else begin
                        r_mtimecmp[h][31:0] <= req_wdata;
                    end
                end
            end
        end
    end

    // Timer interrupt compares the pre-edge registers, so it lags any change by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtip <= '0;
        end else begin
            for (int h = 0; h < NHART; h++) begin
                r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
            end
        end
    end

endmodule

// File: doc/mmio_clint_multi.md
Name: mmio_clint_multi

Overview:
- Multi-hart, parametrised CLINT MMIO slave.
- Owns the free-running 64-bit mtime counter, driven by an internal 1 MHz prescaler derived from FMAX_MHz.
- Holds one mtimecmp register and one msip bit per hart.
- Drives per-hart timer and software interrupt lines to the cores.
- Sits on the MMIO bus behind the memory-map decoder.
- 32-bit register accesses with a registered, one-cycle-latency response.

Parameters:
- FMAX_MHz, 27: core clock in MHz; mtime increments once every FMAX_MHz clk cycles.
- NHART, 2: number of harts (1..16); sizes the mtimecmp, msip and mtip arrays.
- BASE_ADDR, 32'h0200_0000: CLINT base; decode uses req_addr - BASE_ADDR, 16-bit offset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_ready  out  1  request accept.
- req_valid  in  1  request valid.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle pulse: response for the accepted request.
- resp_rdata  out  32  read data; 0 for writes.
- mtime  out  64  current mtime value.
- mtip  out  NHART  per-hart machine timer interrupt pending.
- msip  out  NHART  per-hart machine software interrupt pending.

Behaviour:
- Reset (async, active-high):
  - mtime = 0
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - msip = 0, mtip = 0
  - resp_valid = 0, resp_rdata = 0
  - prescaler = 0
- req_ready is 1 whenever reset is low; back-to-back requests are accepted every cycle.
- Response:
  - A request accepted at edge N gives resp_valid = 1 and resp_rdata from edge N, held for exactly that cycle.
  - resp_valid = 0 on cycles with no accepted request.
- Register map (offset from BASE_ADDR):
  - 0x0000 + 4h: msip[h]. Only bit 0 is stored; other read bits are 0.
  - 0x4000 + 8h: mtimecmp[h][31:0].
  - 0x4004 + 8h: mtimecmp[h][63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
  - For h >= NHART and all other offsets: reads return 0, writes are ignored.
- Read data is sampled pre-write: a read returns the value before any write on the same edge.
- Prescaler:
  - Counts 0..FMAX_MHz-1, wraps to 0.
  - A tick fires when the count equals FMAX_MHz-1.
  - On a tick, mtime <= mtime + 1 (64-bit wrap FFFF..FF -> 0).
  - FMAX_MHz = 1 gives a tick every cycle.
- mtime writes:
  - A half-word write replaces only that half; there is no carry/borrow into the other half.
  - A write on a tick edge wins; that tick is discarded and the prescaler keeps counting.
- mtip:
  - Registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare, using register values before the current edge.
  - mtip therefore lags an mtime/mtimecmp change by one cycle.
  - Writing mtimecmp above mtime clears mtip on the following edge.
- mtime output is the register value directly (no extra delay).
- Reset mid-transaction drops any pending response; no resp_valid follows.

Optional Feature:
- Macro: MMIO_CLINT_MSIP_EN.
- Defined: msip registers are implemented as described above.
- Undefined: no msip storage; msip outputs tied to 0; offsets 0x0000..0x3FFF read 0 and ignore writes.

Test Plan:
- Reset, then read mtimecmp[1] lo/hi -> 0xFFFFFFFF both, one cycle after accept; mtip = 0; mtime = 0.
- FMAX_MHz = 27, run 270 cycles from reset -> mtime = 10; read 0xBFF8 returns 10 on the cycle after its accept.
- Write mtime lo = 0xFFFFFFFF, hi = 0 -> after the next tick, mtime = 0x1_0000_0000. Write mtime lo on a tick edge -> written value held with no +1.
- Write mtimecmp[0] = 5 (hi = 0 first, then lo = 5), mtime reaching 5 -> mtip[0] rises one cycle after mtime = 5; mtip[1] stays 0. Write mtimecmp[0] hi = 1 -> mtip[0] clears the next cycle.
- With MMIO_CLINT_MSIP_EN: write 0x0004 = 0xFFFF -> msip[1] = 1, read 0x0004 = 1. Without the macro: msip = 0, read = 0.
- Read offset 0x4010 with NHART = 2 -> 0; write there -> no state change. Assert reset mid-request -> no resp_valid.
